// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared encodings for the timer bank: FSM states, register offsets, CTRL fields, modes
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'd0,
        MODE_PULSE   = 2'd1,
        MODE_STICKY  = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_t;

    // Word offsets inside a channel's 16-byte window (byte offset >> 2)
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_PEND    = 4;

    // The reserved mode code behaves exactly like one-shot
    function automatic mode_t eff_mode(input mode_t m);
        return (m == MODE_RSVD) ? MODE_ONESHOT : m;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-counting timer channel: CTRL/PRESET/COUNT registers and its FSM
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_we,
    input  logic             preset_we,
    input  logic [CNT_W-1:0] wdata,
    output logic [31:0]      ctrl_rd,
    output logic [31:0]      preset_rd,
    output logic [31:0]      count_rd,
    output logic             irq
);

    state_t           state;
    mode_t            mode;
    mode_t            run_mode;
    logic             en;
    logic             im;
    logic             pend;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             stop;
    logic             pend_set;
    logic             pend_clr;

    assign run_mode = eff_mode(mode);
    assign stop     = ctrl_we && !wdata[CTRL_EN];
    assign pend_set = (state == ST_INT) && (run_mode == MODE_STICKY);
    assign pend_clr = ctrl_we && wdata[CTRL_PEND];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            mode   <= MODE_ONESHOT;
            en     <= 1'b0;
            im     <= 1'b0;
            pend   <= 1'b0;
            preset <= '0;
            count  <= '0;
        end else begin
            // A stopping CTRL write freezes COUNT, so hardware progress is skipped
            if (!stop) begin
                case (state)
                    ST_LOAD: begin
                        count <= preset;
                        state <= ST_CNT;
                    end
                    ST_CNT: begin
                        if (count != '0) count <= count - CNT_W'(1);
                        else             state <= ST_INT;
                    end
                    ST_INT: begin
                        if (run_mode == MODE_ONESHOT) begin
                            en    <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                    default: ;
                endcase
            end

            // Bus write overrides the hardware EN clear; a re-enable from INT restarts
            if (ctrl_we) begin
                en   <= wdata[CTRL_EN];
                mode <= mode_t'(wdata[CTRL_MODE_HI:CTRL_MODE_LO]);
                im   <= wdata[CTRL_IM];
                if (!wdata[CTRL_EN])
                    state <= ST_IDLE;
                else if (state == ST_IDLE || state == ST_INT)
                    state <= ST_LOAD;
            end

            pend <= pend_set || (pend && !pend_clr);

            if (preset_we) preset <= wdata;
        end
    end

    assign irq       = im && (pend || (state == ST_INT && run_mode != MODE_STICKY));
    assign ctrl_rd   = {27'd0, pend, im, mode, en};
    assign preset_rd = 32'(preset);
    assign count_rd  = 32'(count);

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of independent timer channels behind a word-addressed register window
module timer_bank
    import timer_pkg::*;
#(
    parameter int          NUM_CH = 2,
    parameter int          CNT_W  = 32,
    parameter logic [31:0] BASE   = 32'h0000_7f00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [29:0]       addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              hit,
    output logic [NUM_CH-1:0] irq
);

    logic [29:0] woff;
    logic [27:0] sel_ch;
    logic [1:0]  sel_word;
    logic        in_range;

    logic [31:0] ctrl_rd   [NUM_CH];
    logic [31:0] preset_rd [NUM_CH];
    logic [31:0] count_rd  [NUM_CH];

    // Addresses below BASE wrap to huge offsets and fall out of range
    assign woff     = addr - BASE[31:2];
    assign sel_ch   = woff[29:2];
    assign sel_word = woff[1:0];
    assign in_range = woff < 30'(4 * NUM_CH);
    assign hit      = in_range && (sel_word != OFF_RSVD);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = hit && we && (sel_ch == 28'(i));

        timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .ctrl_we   (sel && sel_word == OFF_CTRL),
            .preset_we (sel && sel_word == OFF_PRESET),
            .wdata     (wdata[CNT_W-1:0]),
            .ctrl_rd   (ctrl_rd[i]),
            .preset_rd (preset_rd[i]),
            .count_rd  (count_rd[i]),
            .irq       (irq[i])
        );
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hit && sel_ch == 28'(i)) begin
                case (sel_word)
                    OFF_CTRL:   rdata = ctrl_rd[i];
                    OFF_PRESET: rdata = preset_rd[i];
                    OFF_COUNT:  rdata = count_rd[i];
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - randomized and directed bench for timer_bank against a behavioural model
module tb_timer_bank;

    localparam int NCH    = 3;
    localparam int CW     = 8;
    localparam int BASE_B = 'h7f00;
    localparam int MASK   = (1 << CW) - 1;
    localparam int P_IDLE = 0, P_LOAD = 1, P_CNT = 2, P_INT = 3;
    localparam int C0 = BASE_B, C1 = BASE_B + 16, C2 = BASE_B + 32;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [29:0]     addr  = '0;
    logic            we    = 1'b0;
    logic [31:0]     wdata = '0;
    logic [31:0]     rdata;
    logic            hit;
    logic [NCH-1:0]  irq;

    int n_cmp = 0;
    int n_bad = 0;

    int m_ph     [NCH];
    int m_mode   [NCH];
    int m_preset [NCH];
    int m_count  [NCH];
    bit m_en     [NCH];
    bit m_im     [NCH];
    bit m_pend   [NCH];

    timer_bank #(
        .NUM_CH (NCH),
        .CNT_W  (CW),
        .BASE   (32'h0000_7f00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .hit   (hit),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void decode(input logic [29:0] a, output bit h, output int c, output int o);
        longint ba;
        longint rel;
        ba  = {a, 2'b00};
        rel = ba - BASE_B;
        h = 0; c = 0; o = 0;
        if (rel >= 0 && rel < 16 * NCH) begin
            c = int'(rel / 16);
            o = int'(rel % 16);
            h = (o != 12);
        end
    endfunction

    function automatic bit model_hit(input logic [29:0] a);
        bit h; int c, o;
        decode(a, h, c, o);
        return h;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [29:0] a);
        bit h; int c, o;
        decode(a, h, c, o);
        if (!h) return 32'd0;
        case (o)
            0:       return {27'd0, m_pend[c], m_im[c], 2'(m_mode[c]), m_en[c]};
            4:       return 32'(m_preset[c]);
            default: return 32'(m_count[c]);
        endcase
    endfunction

    function automatic logic [NCH-1:0] model_irq();
        logic [NCH-1:0] r;
        int eff;
        for (int i = 0; i < NCH; i++) begin
            eff  = (m_mode[i] == 3) ? 0 : m_mode[i];
            r[i] = m_im[i] && (m_pend[i] || (m_ph[i] == P_INT && eff != 2));
        end
        return r;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_ph[i] = P_IDLE; m_mode[i] = 0; m_preset[i] = 0; m_count[i] = 0;
            m_en[i] = 0; m_im[i] = 0; m_pend[i] = 0;
        end
    endfunction

    function automatic void model_step();
        bit h; int c, o;
        bit wc, wp, stop, pset;
        int eff, nph, ncnt;
        bit nen;
        decode(addr, h, c, o);
        for (int i = 0; i < NCH; i++) begin
            wc   = we && h && c == i && o == 0;
            wp   = we && h && c == i && o == 4;
            eff  = (m_mode[i] == 3) ? 0 : m_mode[i];
            stop = wc && !wdata[0];
            pset = (m_ph[i] == P_INT) && eff == 2;
            nph = m_ph[i]; ncnt = m_count[i]; nen = m_en[i];
            if (!stop) begin
                if (m_ph[i] == P_LOAD) begin
                    ncnt = m_preset[i]; nph = P_CNT;
                end else if (m_ph[i] == P_CNT) begin
                    if (m_count[i] != 0) ncnt = m_count[i] - 1;
                    else nph = P_INT;
                end else if (m_ph[i] == P_INT) begin
                    if (eff == 0) begin nen = 0; nph = P_IDLE; end
                    else nph = P_LOAD;
                end
            end
            if (wc) begin
                nen       = wdata[0];
                m_mode[i] = int'(wdata[2:1]);
                m_im[i]   = wdata[3];
                if (!wdata[0]) nph = P_IDLE;
                else if (m_ph[i] == P_IDLE || m_ph[i] == P_INT) nph = P_LOAD;
            end
            m_pend[i] = pset || (m_pend[i] && !(wc && wdata[4]));
            if (wp) m_preset[i] = int'(wdata) & MASK;
            m_ph[i] = nph; m_count[i] = ncnt; m_en[i] = nen;
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) model_clear();
        else model_step();
    end

    always @(negedge clk) begin
        #2;
        check("hit", 32'(hit), 32'(model_hit(addr)));
        check("rdata", rdata, model_rdata(addr));
        check("irq", 32'(irq), 32'(model_irq()));
    end

    task automatic wr(input int b, input logic [31:0] d);
        addr  = 30'(b >> 2);
        we    = 1'b1;
        wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input int b);
        addr = 30'(b >> 2);
        #1;
    endtask

    initial begin
        int r, ch, word;
        bit seen;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd(C0);
        check("rst_hit", 32'(hit), 1);
        check("rst_ctrl0", rdata, 0);
        check("rst_irq", 32'(irq), 0);
        rd(C2 + 4);
        check("rst_preset2", rdata, 0);
        @(negedge clk);

        // one-shot with IM: preset 3
        wr(C0 + 4, 3);
        wr(C0, 32'h9);
        addr = 30'((C0 + 8) >> 2);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk); #1;
            if (j == 1) check("m0_count_k1", rdata, 3);
            if (j == 4) begin
                check("m0_count_k4", rdata, 0);
                check("m0_irq_k4", 32'(irq[0]), 0);
            end
        end
        check("m0_irq_k5", 32'(irq[0]), 1);
        @(negedge clk);
        rd(C0);
        check("m0_ctrl_k6", rdata, 32'h8);
        check("m0_irq_k6", 32'(irq[0]), 0);

        // auto-reload pulse: preset 2, period 5
        wr(C1 + 4, 2);
        wr(C1, 32'hB);
        addr = 30'((C1 + 8) >> 2);
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk); #1;
            check("m1_irq_pulse", 32'(irq[1]), 32'(j == 4 || j == 9 || j == 14));
            if (j == 1) check("m1_count_1", rdata, 2);
            if (j == 2) check("m1_count_2", rdata, 1);
            if (j == 3) check("m1_count_3", rdata, 0);
            if (j == 6) check("m1_count_6", rdata, 2);
        end
        wr(C1, 0);

        // auto-reload sticky: preset 1, then W1C mid-count
        wr(C2 + 4, 1);
        wr(C2, 32'hD);
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk); #1;
            check("m2_irq_held", 32'(irq[2]), 32'(j >= 4));
        end
        wr(C2, 32'h1D);
        rd(C2);
        check("m2_ctrl_clr", rdata, 32'hD);
        check("m2_irq_clr", 32'(irq[2]), 0);
        @(negedge clk); #1;
        check("m2_irq_clr2", 32'(irq[2]), 0);
        @(negedge clk); #1;
        check("m2_irq_again", 32'(irq[2]), 1);
        wr(C2, 32'h10);

        // PEND set and W1C in the same cycle keeps PEND
        wr(C2 + 4, 0);
        wr(C2, 32'hD);
        repeat (2) @(negedge clk);
        wr(C2, 32'h1D);
        rd(C2);
        check("pend_collide_ctrl", rdata, 32'h1D);
        check("pend_collide_irq", 32'(irq[2]), 1);
        wr(C2, 32'h10);

        // stop mid-count
        wr(C0 + 4, 10);
        wr(C0, 32'h1);
        repeat (6) @(negedge clk);
        rd(C0 + 8);
        check("stop_before", rdata, 5);
        wr(C0, 0);
        rd(C0 + 8);
        check("stop_count", rdata, 5);
        repeat (3) @(negedge clk);
        rd(C0 + 8);
        check("stop_count_hold", rdata, 5);
        check("stop_irq", 32'(irq[0]), 0);
        rd(C0);
        check("stop_ctrl", rdata, 0);
        wr(C0 + 4, 7);
        rd(C0 + 8);
        check("preset_wr_count", rdata, 5);
        rd(C0 + 4);
        check("preset_wr_preset", rdata, 7);

        // truncation and decode holes
        wr(C2 + 4, 32'h1FF);
        rd(C2 + 4);
        check("trunc_preset", rdata, 32'hFF);
        check("trunc_hit", 32'(hit), 1);
        rd(C2 + 12);
        check("hole_hit", 32'(hit), 0);
        check("hole_rdata", rdata, 0);
        rd(BASE_B + 48);
        check("oob_hit", 32'(hit), 0);
        rd(BASE_B - 4);
        check("below_hit", 32'(hit), 0);
        @(negedge clk);

        // async reset with irq pending
        wr(C1 + 4, 0);
        wr(C1, 32'hD);
        seen = 0;
        for (int j = 0; j < 10 && !seen; j++) begin
            @(negedge clk);
            seen = irq[1];
        end
        check("arst_irq_up", 32'(seen), 1);
        addr = 30'(C1 >> 2);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("arst_irq", 32'(irq), 0);
        check("arst_ctrl1", rdata, 0);
        addr = 30'((C2 + 4) >> 2);
        #1;
        check("arst_preset2", rdata, 0);
        addr = 30'((C0 + 8) >> 2);
        #1;
        check("arst_count0", rdata, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        rd(C1 + 8);
        check("arst_no_count", rdata, 0);
        check("arst_no_irq", 32'(irq), 0);

        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                we    = 1'b0;
                @(negedge clk);
                reset = 1'b0;
            end
            r    = int'($urandom_range(0, 99));
            ch   = int'($urandom_range(0, 3));
            word = int'($urandom_range(0, 3));
            if (r < 5) addr = 30'($urandom);
            else       addr = 30'((BASE_B + ch * 16 + word * 4) >> 2);
            we = ($urandom_range(0, 99) < 25);
            if (word == 0) begin
                wdata = $urandom;
                if ($urandom_range(0, 1) == 1) wdata[0] = 1'b1;
            end else if (word == 1) begin
                wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 6));
            end else begin
                wdata = $urandom;
            end
        end
        we = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
